// File: rtl/v_reg_reader_pkg.sv
// Shared types and width helpers for the vector register read-side sequencer.
package v_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned v_vlen_lp  = 8;
  localparam int unsigned v_vdw_lp   = 32;
  localparam int unsigned v_lanes_lp = 4;

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  localparam int unsigned v_addr_width_lp     = safe_clog2(v_vlen_lp);
  localparam int unsigned v_len_width_lp      = safe_clog2(v_vlen_lp + 1);
  localparam int unsigned v_lane_cnt_width_lp = safe_clog2(v_lanes_lp + 1);

  typedef struct packed {
    logic [v_lanes_lp-1:0][v_vdw_lp-1:0] data;
    logic [v_lane_cnt_width_lp-1:0]      lanes;
  } row_s;

endpackage

// File: rtl/v_reg_reader_row_buffer.sv
// Two-entry row FIFO; the head row is drained one lane at a time via lane_q.
module v_row_buffer
  import v_pkg::*;
#(
  parameter int unsigned lanes_p      = 4,
  parameter int unsigned vdw_p        = 32,
  parameter int unsigned lcnt_width_p = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enq_i,
  input  logic [lanes_p*vdw_p-1:0]   enq_data_i,
  input  logic [lcnt_width_p-1:0]    enq_lanes_i,
  input  logic                       deq_i,
  output logic                       v_o,
  output logic                       ready_o,
  output logic [vdw_p-1:0]           data_o
);

  localparam int unsigned lane_idx_w_lp = safe_clog2(lanes_p);

  logic [1:0][lanes_p*vdw_p-1:0] mem_q, mem_d;
  logic [1:0][lcnt_width_p-1:0]  lanes_q, lanes_d;
  logic                          wr_ptr_q, wr_ptr_d;
  logic                          rd_ptr_q, rd_ptr_d;
  logic [1:0]                    count_q, count_d;
  logic [lane_idx_w_lp-1:0]      lane_q, lane_d;
  logic                          pop;

  always_comb begin
    mem_d    = mem_q;
    lanes_d  = lanes_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    count_d  = count_q;

    pop     = deq_i && ((lcnt_width_p'(lane_q) + lcnt_width_p'(1)) == lanes_q[rd_ptr_q]);
    v_o     = (count_q != 2'd0);
    // A slot freed by this cycle's final-lane drain may be refilled in the same cycle.
    ready_o = (count_q != 2'd2) || pop;
    data_o  = mem_q[rd_ptr_q][lane_q*vdw_p +: vdw_p];

    if (enq_i) begin
      mem_d[wr_ptr_q]   = enq_data_i;
      lanes_d[wr_ptr_q] = enq_lanes_i;
      wr_ptr_d          = ~wr_ptr_q;
    end

    if (deq_i) begin
      if (pop) begin
        lane_d   = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        lane_d = lane_q + lane_idx_w_lp'(1);
      end
    end

    case ({enq_i, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q    <= '0;
      lanes_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      lane_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      lanes_q  <= lanes_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
    end
  end

endmodule

// File: rtl/v_reg_reader.sv
// Drains a vector from the banked register file, one row per fetch, one element per transfer.
// Optional stall counter output enabled by defining V_REG_READER_STALL_CNT_EN.
module v_reg_reader
  import v_pkg::*;
#(
  parameter int unsigned vlen_p  = v_vlen_lp,
  parameter int unsigned vdw_p   = v_vdw_lp,
  parameter int unsigned lanes_p = v_lanes_lp,
  localparam int unsigned addr_width_lp = safe_clog2(vlen_p),
  localparam int unsigned len_width_lp  = safe_clog2(vlen_p + 1),
  localparam int unsigned rows_lp       = vlen_p / lanes_p
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             start_v_i,
  output logic                             start_ready_o,
  input  logic [len_width_lp-1:0]          len_i,
  output logic [lanes_p*addr_width_lp-1:0] r_addr_o,
  input  logic [lanes_p*vdw_p-1:0]         r_data_i,
  output logic [vdw_p-1:0]                 data_o,
  output logic                             v_o,
  input  logic                             ready_i,
  output logic                             last_o,
  output logic                             busy_o
`ifdef V_REG_READER_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int unsigned row_width_lp  = safe_clog2(rows_lp + 1);
  localparam int unsigned lcnt_width_lp = safe_clog2(lanes_p + 1);

  state_e                           state_q, state_d;
  logic [len_width_lp-1:0]          len_q, len_d;
  logic [len_width_lp-1:0]          elem_q, elem_d;
  logic [row_width_lp-1:0]          rows_q, rows_d;
  logic [row_width_lp-1:0]          fetch_q, fetch_d;
  logic [lanes_p*addr_width_lp-1:0] addr_q, addr_d;
  logic [lanes_p*addr_width_lp-1:0] row_addr;
  logic [len_width_lp:0]            rows_full;
  logic [len_width_lp-1:0]          rem;
  logic [lcnt_width_lp-1:0]         fetch_lanes;
  logic                             fetch, xfer;
  logic                             buf_v, buf_ready;
  logic [vdw_p-1:0]                 buf_data;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    elem_d  = elem_q;
    rows_d  = rows_q;
    fetch_d = fetch_q;

    start_ready_o = (state_q == IDLE);
    busy_o        = (state_q != IDLE);
    v_o           = (state_q == RUN) && buf_v;
    xfer          = v_o && ready_i;
    last_o        = v_o && (elem_q == (len_q - len_width_lp'(1)));
    data_o        = v_o ? buf_data : '0;

    fetch = (state_q == RUN) && (fetch_q < rows_q) && buf_ready;

    row_addr = '0;
    for (int unsigned i = 0; i < lanes_p; i++) begin
      row_addr[i*addr_width_lp +: addr_width_lp] =
        addr_width_lp'(fetch_q) * addr_width_lp'(lanes_p) + addr_width_lp'(i);
    end
    addr_d   = fetch ? row_addr : addr_q;
    r_addr_o = addr_d;

    // Only the final row of a length that is not a lane multiple is partial.
    rem = len_q % len_width_lp'(lanes_p);
    if ((fetch_q == (rows_q - row_width_lp'(1))) && (rem != '0)) begin
      fetch_lanes = lcnt_width_lp'(rem);
    end else begin
      fetch_lanes = lcnt_width_lp'(lanes_p);
    end

    rows_full = ((len_width_lp+1)'(len_i) + (len_width_lp+1)'(lanes_p - 1)) /
                (len_width_lp+1)'(lanes_p);

    case (state_q)
      IDLE: begin
        if (start_v_i) begin
          len_d   = len_i;
          elem_d  = '0;
          fetch_d = '0;
          rows_d  = row_width_lp'(rows_full);
          state_d = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fetch) begin
          fetch_d = fetch_q + row_width_lp'(1);
        end
        if (xfer) begin
          elem_d = elem_q + len_width_lp'(1);
          if (last_o) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      elem_q  <= '0;
      rows_q  <= '0;
      fetch_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      elem_q  <= elem_d;
      rows_q  <= rows_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
    end
  end

  v_row_buffer #(
    .lanes_p      (lanes_p),
    .vdw_p        (vdw_p),
    .lcnt_width_p (lcnt_width_lp)
  ) u_row_buffer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enq_i       (fetch),
    .enq_data_i  (r_data_i),
    .enq_lanes_i (fetch_lanes),
    .deq_i       (xfer),
    .v_o         (buf_v),
    .ready_o     (buf_ready),
    .data_o      (buf_data)
  );

`ifdef V_REG_READER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_v_i && start_ready_o) begin
      stall_d = '0;
    end else if (v_o && !ready_i && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  len_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (start_v_i && start_ready_o) |-> (len_i <= len_width_lp'(vlen_p)));

endmodule

// File: doc/v_reg_reader.md
Name: v_reg_reader

Overview:
- Drain sequencer on the read side of the banked vector register file.
- Start command with an element count → drives all per-lane read addresses one row (lanes_p elements) per cycle → captures the returned row → serializes elements onto a valid/ready stream in index order.
- Sits between the register file and the store/writeback path.
- Two-row buffer lets the next row fetch overlap draining of the current row.

Parameters:
- vlen_p, 8, elements per vector; multiple of lanes_p.
- vdw_p, 32, bits per element.
- lanes_p, 4, lanes = banks; power of two.
- addr_width_lp, BSG_SAFE_CLOG2(vlen_p), element index width (localparam).
- len_width_lp, BSG_SAFE_CLOG2(vlen_p+1), count width (localparam).
- rows_lp, vlen_p/lanes_p, rows per vector (localparam).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_v_i  in  1  start request
- start_ready_o  out  1  high only in IDLE
- len_i  in  len_width_lp  elements to drain, 0..vlen_p; sampled on start handshake
- r_addr_o  out  lanes_p x addr_width_lp  per-lane element index to register file
- r_data_i  in  lanes_p x vdw_p  per-lane read data, combinational same cycle
- data_o  out  vdw_p  streamed element
- v_o  out  1  data_o valid
- ready_i  in  1  consumer ready; transfer when v_o & ready_i
- last_o  out  1  high with final element
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, reset_i).
- Reset values: start_ready_o=1 and all other outputs 0 (r_addr_o=0). Counters, buffers and state cleared.
- Reset mid-operation aborts immediately; no further v_o.
- Element mapping: element e sits in lane e%lanes_p, row e/lanes_p. During a fetch of row r, r_addr_o[i] = r*lanes_p+i. r_addr_o holds its last value when not fetching.
- States:
  - IDLE: start_v_i & start_ready_o → latch len_i, row counter=0, element counter=0. Go to RUN, or to DONE if len_i==0.
  - RUN:
    - Each cycle a buffer slot is free and rows remain, present row addresses and capture r_data_i at the clock edge.
    - Rows fetched = ceil(len/lanes_p).
    - Drain the oldest buffered row, lane 0 upward, one element per transfer.
    - Partial last row: only len%lanes_p lanes are emitted.
    - Fetch and the drain of the last element of a slot in the same cycle are both honoured, so a full throughput of 1 element/cycle is sustained.
  - After the transfer with last_o=1 → DONE.
  - DONE: one cycle, busy_o=1, v_o=0 → IDLE.
- Latency: start accepted at cycle 0, row 0 fetched at cycle 1, first v_o at cycle 2.
- v_o/data_o/last_o stable while v_o & ~ready_i.
- last_o=1 exactly when element counter == len-1.
- start_v_i ignored while busy.
- len_i > vlen_p is a precondition violation; assert in simulation.

Optional Feature:
- V_REG_READER_STALL_CNT_EN defined: adds output stall_cnt_o (32 bits).
  - Counts cycles with v_o & ~ready_i, saturating at all-ones.
  - Cleared by reset and on each accepted start.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package v_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - a row struct (lanes_p x vdw_p data plus lane count);
  - width helper constants shared with the register file.
- One natural sub-module: v_row_buffer, a 2-entry row FIFO with enq/deq and a per-lane read pointer.

Test Plan:
- len=8, lanes=4, ready_i always 1, element e preloaded as 0x100+e → data_o 0x100..0x107 on cycles 2..9. last_o with 0x107; r_addr_o rows {0,1,2,3} then {4,5,6,7}.
- len=5 → five outputs 0x100..0x104; lanes 1-3 of row 1 never emitted; last_o on 0x104.
- len=0 → start accepted, busy_o high 1 cycle, v_o never asserted, start_ready_o back after 2 cycles.
- len=8 with ready_i toggling 1,0 → data_o held during stalls, all 8 elements in order, no extra fetch when both slots full.
- reset_i pulsed at cycle 4 of an 8-element drain → next cycle v_o=0, busy_o=0, start_ready_o=1. A new len=2 start then produces 0x100, 0x101.
- With V_REG_READER_STALL_CNT_EN, len=4, ready_i low for the first 3 valid cycles → stall_cnt_o=3 at completion.
